// File: rtl/serial_adder_nbit_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_nbit_pkg
// Shared definitions for the digit-serial add/subtract unit:
//   state_e    FSM state encoding (IDLE / RUN / DONE)
//   cnt_width  width of the digit counter for a given number of steps
//   full_add   1-bit full adder returning {carry_out, sum}
// -----------------------------------------------------------------------------
package serial_adder_nbit_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // A single-step configuration still needs a 1-bit counter so the port
   // and compare logic stay well-formed.
   function automatic int cnt_width(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/serial_adder_nbit_digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Combinational ripple chain of DIGIT 1-bit full adders.
// Ports:
//   x, y   in  DIGIT  operand digits
//   ci     in  1      carry into bit 0
//   s      out DIGIT  digit sum
//   co     out 1      carry out of bit DIGIT-1
//   c_msb  out 1      carry into bit DIGIT-1 (used for signed overflow)
// -----------------------------------------------------------------------------
module digit_adder
   import serial_adder_nbit_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   // c[k] is the carry into bit k; c[DIGIT] is the carry out.
   logic [DIGIT:0] c;

   assign c[0] = ci;

   generate
      for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
         assign {c[gi+1], s[gi]} = full_add(x[gi], y[gi], c[gi]);
      end
   endgenerate

   assign co    = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_nbit.sv
// -----------------------------------------------------------------------------
// serial_adder_nbit
// Digit-serial add/subtract unit. Operands are consumed DIGIT bits per clock,
// LSB first, with the inter-digit carry held in a flip-flop. A result appears
// STEPS = WIDTH/DIGIT cycles after an accepted start, flagged by a one-cycle
// done pulse.
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, accepted only when not busy
//   sub    in   1      0: a+b+cin, 1: a-b
//   a, b   in   WIDTH  operands, captured on accepted start
//   cin    in   1      carry-in for add mode
//   busy   out  1      operation in progress
//   done   out  1      one-cycle result-valid pulse
//   sum    out  WIDTH  result, held until the next completion
//   cout   out  1      carry out of MSB (subtract: 1 = no borrow)
//   ovf    out  1      signed overflow
// -----------------------------------------------------------------------------
module serial_adder_nbit
   import serial_adder_nbit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CNT_W = cnt_width(STEPS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STEPS - 1);

   generate
      if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
         $error("serial_adder_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   res_q;
   logic [WIDTH-1:0]   res_next;
   logic               carry_q;
   logic [CNT_W-1:0]   idx_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               ovf_q;

   logic               accept;
   logic               last_digit;

   logic [DIGIT-1:0]   dig_s;
   logic               dig_co;
   logic               dig_cmsb;

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      last_digit = (idx_q == LAST_IDX);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (last_digit) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            // A start here chains straight into the next operation.
            if (start) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit_adder (
      .x     (a_q[DIGIT-1:0]),
      .y     (b_q[DIGIT-1:0]),
      .ci    (carry_q),
      .s     (dig_s),
      .co    (dig_co),
      .c_msb (dig_cmsb)
   );

   // Result bits enter at the top and move down one digit per step, so after
   // STEPS digits the first digit computed sits in the least significant slot.
   assign res_next = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         // Subtraction is a + ~b + 1: invert b here and force the carry-in.
         b_q     <= sub ? ~b : b;
         carry_q <= sub ? 1'b1 : cin;
         idx_q   <= '0;
      end else if (state_q == S_RUN) begin
         a_q     <= a_q >> DIGIT;
         b_q     <= b_q >> DIGIT;
         res_q   <= res_next;
         carry_q <= dig_co;
         if (last_digit) begin
            idx_q  <= '0;
            sum_q  <= res_next;
            cout_q <= dig_co;
            ovf_q  <= dig_cmsb ^ dig_co;
         end else begin
            idx_q  <= idx_q + CNT_W'(1);
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
